pc_gen_ras: RTL

Parametrised program-counter generator for the pipelined core's fetch stage. It adds three things to the basic next-PC selection (sequential, branch, 26-bit jump):
- stall and exception redirection, with an exception PC capture;
- register-indirect jumps;
- a circular return-address stack (RAS) that predicts `jr $ra` returns and tracks overflow and underflow.

It sits between the decode/branch-resolve logic and the instruction memory address port.

---
 rtl/pc_gen_ras.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_gen_ras.sv
// Fetch-stage program-counter generator with stall/exception redirect,
// register-indirect jumps and a circular return-address stack.
module pc_gen_ras #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0180),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Stall,
  input  logic            Exception,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] SignImm,
  input  logic            Jump,
  input  logic            Call,
  input  logic            Ret,
  input  logic            JumpReg,
  input  logic [25:0]     Jump_low_26Bit,
  input  logic [XLEN-1:0] RegTarget,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] EPC,
  output logic [XLEN-1:0] RasTop,
  output logic            RasEmpty,
  output logic            RasOverflow,
  output logic            RasUnderflow
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [PtrW-1:0] tp_q, tp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_jump;
  logic [XLEN-1:0] pc_branch;
  logic [XLEN-1:0] ras_top;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign pc_jump   = {pc_plus4[XLEN-1:28], Jump_low_26Bit, 2'b00};
  assign pc_branch = pc_plus4 + (SignImm << 2);
  assign ras_top   = (cnt_q != '0) ? ras_q[tp_q] : '0;

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    tp_d  = tp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (Exception) begin
      // Only the count is cleared; stale entries are unreachable until overwritten.
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
      cnt_d = '0;
    end else if (!Stall) begin
      if (Ret) begin
        if (cnt_q != '0) begin
          pc_d  = ras_top;
          tp_d  = tp_q - PtrW'(1);
          cnt_d = cnt_q - CntW'(1);
        end else begin
          pc_d  = RegTarget;
          unf_d = 1'b1;
        end
      end else if (Call) begin
        pc_d = pc_jump;
        push = 1'b1;
        tp_d = tp_q + PtrW'(1);
        // A full stack wraps onto its oldest entry and the count saturates.
        if (cnt_q == CntFull) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else if (JumpReg) begin
        pc_d = RegTarget;
      end else if (Jump) begin
        pc_d = pc_jump;
      end else if (PCSrc) begin
        pc_d = pc_branch;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      tp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ras_q[tp_d] <= pc_plus4;
    end
  end

  assign PC           = pc_q;
  assign PCPlus4      = pc_plus4;
  assign EPC          = epc_q;
  assign RasTop       = ras_top;
  assign RasEmpty     = (cnt_q == '0);
  assign RasOverflow  = ovf_q;
  assign RasUnderflow = unf_q;

endmodule
